// File: rtl/controller_pipe_if.sv
// controller_pipe_if: control bundle between the pipelined controller and the datapath.
// master is the controller side, slave is the datapath side.
interface controller_pipe_if;
   logic [19:0] InstrD;
   logic [3:0] ALUFlags;
   logic FlushE;
   logic [1:0] RegSrcD;
   logic [1:0] ImmSrcD;
   logic ALUSrcE;
   logic [2:0] ALUControlE;
   logic MemWriteM;
   logic MemtoRegE;
   logic RegWriteM;
   logic MemtoRegW;
   logic RegWriteW;
   logic PCSrcW;
   modport master (
      input InstrD, ALUFlags, FlushE,
      output RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, MemWriteM, MemtoRegE,
      RegWriteM, MemtoRegW, RegWriteW, PCSrcW
   );
   modport slave (
      output InstrD, ALUFlags, FlushE,
      input RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, MemWriteM, MemtoRegE,
      RegWriteM, MemtoRegW, RegWriteW, PCSrcW
   );
endinterface

// File: rtl/controller_pipe.sv
// controller_pipe: 5-stage ARM-subset control unit; decodes in D, conditions in E, pipes controls to M/W.
module controller_pipe (
   input logic clk,
   input logic reset,
   controller_pipe_if.master bus
);
   logic [3:0] condD;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] cmd;
   logic [3:0] rd;
   logic isDp, isMem, isBr, isLdr, isStr, isCmp, dpOk, addSub, sBit;
   logic regWriteD, memWriteD, memtoRegD, pcsD, aluSrcD;
   logic [2:0] aluControlD;
   logic [1:0] flagWriteD;
   logic [3:0] condE;
   logic [1:0] flagWriteE;
   logic regWriteE, memWriteE, memtoRegE, pcsE, aluSrcE;
   logic [2:0] aluControlE;
   logic condExE;
   logic [3:0] flags;
   logic regWriteM, memWriteM, memtoRegM, pcSrcM;
   logic regWriteW, memtoRegW, pcSrcW;
   assign condD = bus.InstrD[19:16];
   assign op = bus.InstrD[15:14];
   assign funct = bus.InstrD[13:8];
   assign rd = bus.InstrD[3:0];
   assign cmd = funct[4:1];
   assign isDp = op == 2'b00;
   assign isMem = op == 2'b01;
   assign isBr = op == 2'b10;
   assign isLdr = isMem & funct[0];
   assign isStr = isMem & ~funct[0];
   assign isCmp = isDp & (cmd == 4'b1010);
   assign addSub = (cmd == 4'b0100) | (cmd == 4'b0010) | (cmd == 4'b1010);
   assign dpOk = isDp & (addSub | (cmd == 4'b0000) | (cmd == 4'b1100));
   assign sBit = funct[0] | isCmp;
   assign aluControlD = (!dpOk || cmd == 4'b0100) ? 3'b000 :
                        cmd == 4'b0000 ? 3'b001 :
                        cmd == 4'b1100 ? 3'b010 : 3'b011;
   assign aluSrcD = dpOk ? funct[5] : (isMem | isBr);
   assign regWriteD = (dpOk & ~isCmp) | isLdr;
   assign memWriteD = isStr;
   assign memtoRegD = isLdr;
   assign flagWriteD = {dpOk & sBit, dpOk & sBit & addSub};
   assign pcsD = ((rd == 4'hf) & regWriteD) | isBr;
   assign bus.RegSrcD = {isStr, isBr};
   assign bus.ImmSrcD = isBr ? 2'b10 : isMem ? 2'b01 : 2'b00;
   always_ff @(posedge clk) begin
      if (reset || bus.FlushE) begin
         condE <= '0;
         flagWriteE <= '0;
         regWriteE <= 1'b0;
         memWriteE <= 1'b0;
         memtoRegE <= 1'b0;
         pcsE <= 1'b0;
         aluSrcE <= 1'b0;
         aluControlE <= '0;
      end else begin
         condE <= condD;
         flagWriteE <= flagWriteD;
         regWriteE <= regWriteD;
         memWriteE <= memWriteD;
         memtoRegE <= memtoRegD;
         pcsE <= pcsD;
         aluSrcE <= aluSrcD;
         aluControlE <= aluControlD;
      end
   end
   // flags is {N,Z,C,V}
   always_comb begin
      condExE = 1'b0;
      case (condE)
         4'b0000: condExE = flags[2];
         4'b0001: condExE = ~flags[2];
         4'b0010: condExE = flags[1];
         4'b0011: condExE = ~flags[1];
         4'b0100: condExE = flags[3];
         4'b0101: condExE = ~flags[3];
         4'b0110: condExE = flags[0];
         4'b0111: condExE = ~flags[0];
         4'b1000: condExE = flags[1] & ~flags[2];
         4'b1001: condExE = ~flags[1] | flags[2];
         4'b1010: condExE = flags[3] == flags[0];
         4'b1011: condExE = flags[3] != flags[0];
         4'b1100: condExE = ~flags[2] & (flags[3] == flags[0]);
         4'b1101: condExE = flags[2] | (flags[3] != flags[0]);
         4'b1110: condExE = 1'b1;
         default: condExE = 1'b0;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         flags <= '0;
         regWriteM <= 1'b0;
         memWriteM <= 1'b0;
         memtoRegM <= 1'b0;
         pcSrcM <= 1'b0;
         regWriteW <= 1'b0;
         memtoRegW <= 1'b0;
         pcSrcW <= 1'b0;
      end else begin
         if (flagWriteE[1] & condExE) flags[3:2] <= bus.ALUFlags[3:2];
         if (flagWriteE[0] & condExE) flags[1:0] <= bus.ALUFlags[1:0];
         regWriteM <= regWriteE & condExE;
         memWriteM <= memWriteE & condExE;
         memtoRegM <= memtoRegE;
         pcSrcM <= pcsE & condExE;
         regWriteW <= regWriteM;
         memtoRegW <= memtoRegM;
         pcSrcW <= pcSrcM;
      end
   end
   assign bus.ALUSrcE = aluSrcE;
   assign bus.ALUControlE = aluControlE;
   assign bus.MemtoRegE = memtoRegE;
   assign bus.MemWriteM = memWriteM;
   assign bus.RegWriteM = regWriteM;
   assign bus.MemtoRegW = memtoRegW;
   assign bus.RegWriteW = regWriteW;
   assign bus.PCSrcW = pcSrcW;
endmodule

// File: tb/tb_controller_pipe.sv
// tb_controller_pipe: directed scenarios plus randomized run against a behavioural pipeline model.
module tb_controller_pipe;
   typedef struct packed {
      logic regW, memW, memToReg, pcs, aluSrc;
      logic [2:0] aluCtl;
      logic [1:0] fw, regSrc, immSrc;
      logic [3:0] cond;
   } ctl_t;
   localparam logic [19:0] ADD = 20'hE0821, ORR = 20'hE1821, CMP = 20'hE1520, BEQ = 20'h0A000;
   localparam logic [19:0] STR = 20'hE5821, LDR = 20'hE5921, ADDNE = 20'h10821, NOP = 20'hEC000;
   logic clk = 1'b0;
   logic reset;
   int compared = 0;
   int mismatched = 0;
   ctl_t mE;
   logic mRegW, mMemW, mMemToReg, mPcs, wRegW, wMemToReg, wPcs;
   logic [3:0] mFlags;
   logic [3:0] cmdTab [5] = '{4'h4, 4'h2, 4'h0, 4'hc, 4'ha};
   controller_pipe_if bus ();
   controller_pipe dut (.clk(clk), .reset(reset), .bus(bus.master));
   always #5 clk = ~clk;
   function automatic ctl_t decodeRef(input logic [19:0] i);
      ctl_t c;
      logic [5:0] fn;
      logic s, cv, ok, cmp, br;
      c = '0;
      fn = i[13:8];
      s = fn[0];
      cv = 1'b0;
      ok = 1'b1;
      cmp = 1'b0;
      br = 1'b0;
      c.cond = i[19:16];
      case (i[15:14])
         2'd0: begin
            case (fn[4:1])
               4'b0100: begin c.aluCtl = 3'd0; cv = 1'b1; end
               4'b0010: begin c.aluCtl = 3'd3; cv = 1'b1; end
               4'b0000: c.aluCtl = 3'd1;
               4'b1100: c.aluCtl = 3'd2;
               4'b1010: begin c.aluCtl = 3'd3; cv = 1'b1; cmp = 1'b1; s = 1'b1; end
               default: ok = 1'b0;
            endcase
            if (ok) begin
               c.aluSrc = fn[5];
               c.regW = !cmp;
               c.fw = {s, s & cv};
            end else c.aluCtl = 3'd0;
         end
         2'd1: begin
            c.aluSrc = 1'b1;
            c.immSrc = 2'b01;
            if (fn[0]) begin c.regW = 1'b1; c.memToReg = 1'b1; end
            else begin c.memW = 1'b1; c.regSrc = 2'b10; end
         end
         2'd2: begin c.regSrc = 2'b01; c.immSrc = 2'b10; c.aluSrc = 1'b1; br = 1'b1; end
         default: ;
      endcase
      c.pcs = (i[3:0] == 4'hf && c.regW) || br;
      return c;
   endfunction
   function automatic logic condRef(input logic [3:0] cd, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (cd)
         4'd0: return z;
         4'd1: return !z;
         4'd2: return cy;
         4'd3: return !cy;
         4'd4: return n;
         4'd5: return !n;
         4'd6: return v;
         4'd7: return !v;
         4'd8: return cy && !z;
         4'd9: return !cy || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && n == v;
         4'd13: return z || n != v;
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction
   task automatic modelEdge(input logic [19:0] instr, input logic [3:0] af, input logic flush, input logic rst);
      logic ce;
      ce = condRef(mE.cond, mFlags);
      if (rst) begin
         mE = '0;
         {mRegW, mMemW, mMemToReg, mPcs, wRegW, wMemToReg, wPcs} = '0;
         mFlags = '0;
      end else begin
         {wRegW, wMemToReg, wPcs} = {mRegW, mMemToReg, mPcs};
         {mRegW, mMemW, mMemToReg, mPcs} = {mE.regW & ce, mE.memW & ce, mE.memToReg, mE.pcs & ce};
         if (mE.fw[1] && ce) mFlags[3:2] = af[3:2];
         if (mE.fw[0] && ce) mFlags[1:0] = af[1:0];
         mE = flush ? '0 : decodeRef(instr);
      end
   endtask
   task automatic step(input logic [19:0] instr, input logic [3:0] af = 4'h0, input logic flush = 1'b0, input logic rst = 1'b0);
      bus.InstrD = instr;
      bus.ALUFlags = af;
      bus.FlushE = flush;
      reset = rst;
      @(posedge clk);
      modelEdge(instr, af, flush, rst);
      @(negedge clk);
   endtask
   task automatic test_reset();
      step(ADD);
      step(LDR);
      step(ORR, 4'hf, 1'b1, 1'b1);
      compared++;
      if ({bus.ALUSrcE, bus.ALUControlE, bus.MemtoRegE, bus.MemWriteM, bus.RegWriteM, bus.MemtoRegW, bus.RegWriteW, bus.PCSrcW} !== 10'b0) begin
         mismatched++;
         $display("FAIL reset_regs got %b want 0", {bus.ALUSrcE, bus.ALUControlE, bus.MemtoRegE, bus.MemWriteM, bus.RegWriteM, bus.MemtoRegW, bus.RegWriteW, bus.PCSrcW});
      end
   endtask
   task automatic test_add();
      step(NOP, 4'h0, 1'b0, 1'b1);
      bus.InstrD = ADD;
      #1;
      compared++; if ({bus.RegSrcD, bus.ImmSrcD} !== 4'b0000) begin mismatched++; $display("FAIL add_dsrc got %b want 0000", {bus.RegSrcD, bus.ImmSrcD}); end
      step(ADD);
      compared++; if ({bus.ALUSrcE, bus.ALUControlE} !== 4'b0000) begin mismatched++; $display("FAIL add_e got %b want 0000", {bus.ALUSrcE, bus.ALUControlE}); end
      step(NOP);
      step(NOP);
      compared++; if ({bus.RegWriteW, bus.MemtoRegW, bus.PCSrcW} !== 3'b100) begin mismatched++; $display("FAIL add_w got %b want 100", {bus.RegWriteW, bus.MemtoRegW, bus.PCSrcW}); end
   endtask
   task automatic test_cmp_beq(input logic [3:0] af, input logic want);
      step(NOP, 4'h0, 1'b0, 1'b1);
      step(CMP);
      compared++; if (bus.ALUControlE !== 3'b011) begin mismatched++; $display("FAIL cmp_alu got %b want 011", bus.ALUControlE); end
      step(BEQ, af);
      step(NOP);
      compared++; if (bus.RegWriteW !== 1'b0) begin mismatched++; $display("FAIL cmp_regw got %b want 0", bus.RegWriteW); end
      step(NOP);
      compared++; if (bus.PCSrcW !== want) begin mismatched++; $display("FAIL beq_pcsrc af=%b got %b want %b", af, bus.PCSrcW, want); end
   endtask
   task automatic test_mem();
      step(NOP, 4'h0, 1'b0, 1'b1);
      bus.InstrD = STR;
      #1;
      compared++; if ({bus.RegSrcD, bus.ImmSrcD} !== 4'b1001) begin mismatched++; $display("FAIL str_dsrc got %b want 1001", {bus.RegSrcD, bus.ImmSrcD}); end
      step(STR);
      compared++; if (bus.ALUSrcE !== 1'b1) begin mismatched++; $display("FAIL str_alusrc got %b want 1", bus.ALUSrcE); end
      step(LDR);
      compared++; if ({bus.MemWriteM, bus.MemtoRegE} !== 2'b11) begin mismatched++; $display("FAIL str_memw_ldr_e got %b want 11", {bus.MemWriteM, bus.MemtoRegE}); end
      step(NOP);
      step(NOP);
      compared++; if ({bus.RegWriteW, bus.MemtoRegW} !== 2'b11) begin mismatched++; $display("FAIL ldr_w got %b want 11", {bus.RegWriteW, bus.MemtoRegW}); end
   endtask
   task automatic test_cond_fail();
      step(NOP, 4'h0, 1'b0, 1'b1);
      step(CMP);
      step(ADDNE, 4'b0100);
      step(NOP);
      compared++; if (bus.RegWriteM !== 1'b0) begin mismatched++; $display("FAIL addne_m got %b want 0", bus.RegWriteM); end
      step(BEQ);
      compared++; if (bus.RegWriteW !== 1'b0) begin mismatched++; $display("FAIL addne_w got %b want 0", bus.RegWriteW); end
      step(NOP);
      step(NOP);
      compared++; if (bus.PCSrcW !== 1'b1) begin mismatched++; $display("FAIL z_kept got %b want 1", bus.PCSrcW); end
   endtask
   task automatic test_flush();
      step(NOP, 4'h0, 1'b0, 1'b1);
      step(ADD);
      step(ORR, 4'h0, 1'b1);
      compared++; if ({bus.ALUSrcE, bus.ALUControlE, bus.MemtoRegE} !== 5'b0) begin mismatched++; $display("FAIL flush_e got %b want 00000", {bus.ALUSrcE, bus.ALUControlE, bus.MemtoRegE}); end
      compared++; if (bus.RegWriteM !== 1'b1) begin mismatched++; $display("FAIL flush_keeps_m got %b want 1", bus.RegWriteM); end
      step(NOP);
      compared++; if ({bus.RegWriteW, bus.RegWriteM, bus.MemWriteM} !== 3'b100) begin mismatched++; $display("FAIL flush_m got %b want 100", {bus.RegWriteW, bus.RegWriteM, bus.MemWriteM}); end
      step(NOP);
      compared++; if ({bus.RegWriteW, bus.PCSrcW} !== 2'b00) begin mismatched++; $display("FAIL flush_w got %b want 00", {bus.RegWriteW, bus.PCSrcW}); end
   endtask
   task automatic test_reset_mid();
      step(NOP, 4'h0, 1'b0, 1'b1);
      step(CMP);
      step(ADD, 4'b0100);
      step(NOP);
      compared++; if (bus.RegWriteM !== 1'b1) begin mismatched++; $display("FAIL mid_pre got %b want 1", bus.RegWriteM); end
      step(NOP, 4'h0, 1'b0, 1'b1);
      compared++; if ({bus.RegWriteW, bus.RegWriteM} !== 2'b00) begin mismatched++; $display("FAIL mid_reset got %b want 00", {bus.RegWriteW, bus.RegWriteM}); end
      step(BEQ);
      step(NOP);
      step(NOP);
      step(NOP);
      compared++; if (bus.PCSrcW !== 1'b0) begin mismatched++; $display("FAIL mid_flags got %b want 0", bus.PCSrcW); end
   endtask
   task automatic test_random();
      logic [19:0] r;
      ctl_t d;
      step(NOP, 4'h0, 1'b0, 1'b1);
      for (int k = 0; k < 400; k++) begin
         r = 20'($urandom);
         if ($urandom_range(0, 9) < 6) begin
            r[15:14] = 2'b00;
            r[12:9] = cmdTab[$urandom_range(0, 4)];
         end
         if ($urandom_range(0, 5) == 0) r[3:0] = 4'hf;
         if ($urandom_range(0, 2) == 0) r[19:16] = 4'he;
         bus.InstrD = r;
         #1;
         d = decodeRef(r);
         compared++;
         if ({bus.RegSrcD, bus.ImmSrcD} !== {d.regSrc, d.immSrc}) begin
            mismatched++;
            $display("FAIL rnd_d instr=%h got %b want %b", r, {bus.RegSrcD, bus.ImmSrcD}, {d.regSrc, d.immSrc});
         end
         step(r, 4'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
         compared++;
         if ({bus.ALUSrcE, bus.ALUControlE, bus.MemtoRegE, bus.MemWriteM, bus.RegWriteM, bus.MemtoRegW, bus.RegWriteW, bus.PCSrcW} !==
             {mE.aluSrc, mE.aluCtl, mE.memToReg, mMemW, mRegW, wMemToReg, wRegW, wPcs}) begin
            mismatched++;
            $display("FAIL rnd_pipe step=%0d got %b want %b", k,
               {bus.ALUSrcE, bus.ALUControlE, bus.MemtoRegE, bus.MemWriteM, bus.RegWriteM, bus.MemtoRegW, bus.RegWriteW, bus.PCSrcW},
               {mE.aluSrc, mE.aluCtl, mE.memToReg, mMemW, mRegW, wMemToReg, wRegW, wPcs});
         end
      end
   endtask
   initial begin
      bus.InstrD = NOP;
      bus.ALUFlags = 4'h0;
      bus.FlushE = 1'b0;
      reset = 1'b1;
      mE = '0;
      {mRegW, mMemW, mMemToReg, mPcs, wRegW, wMemToReg, wPcs} = '0;
      mFlags = '0;
      @(negedge clk);
      test_reset();
      test_add();
      test_cmp_beq(4'b0100, 1'b1);
      test_cmp_beq(4'b0000, 1'b0);
      test_mem();
      test_cond_fail();
      test_flush();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
